operator_sweep_controller: RTL and testbench
============================================

Name: operator_sweep_controller

Overview:
- Sequences the synth datapath once per audio sample period.
- Issues a burst of VoiceOperatorID_t values 0x00..0xff into the operator pipeline, then waits for the sample generator's sample-ready pulse.
- Latches the finished sample into a one-entry output register with a valid/ack handshake toward the DAC serializer.
- Grants the host a pause window in which parameter RAM writes happen without a sweep in flight.

Parameters:
- CLOCKS_PER_SAMPLE, 1024: sample period in i_Clock cycles. Must be >= NUM_OPERATOR_SLOTS + 16.
- NUM_OPERATOR_SLOTS, 256: IDs issued per sweep. The last ID is NUM_OPERATOR_SLOTS-1, which is 0xff at the default.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  reset, asynchronous, active-high
- i_PauseRequest  in  1  host requests a config window
- o_PauseGrant  out  1  high while paused; no sweep in flight
- o_VoiceOperator  out  8  VoiceOperatorID_t into the operator pipeline
- o_OperatorValid  out  1  high on cycles carrying a sweep ID
- i_SampleReady  in  1  sample generator pulse
- i_Sample  in  16  signed sample from the generator
- o_SampleValid  out  1  output register holds an unconsumed sample
- o_Sample  out  16  signed held sample
- i_SampleAck  in  1  DAC consumed the sample (valid && ack)
- o_Overrun  out  1  sticky: sample tick arrived while not IDLE
- o_SampleDropped  out  1  sticky: a new sample overwrote an unacked one
- i_ClearFlags  in  1  synchronous clear of both sticky flags

Behaviour:

Reset values (all outputs):
- o_VoiceOperator = 0x00; o_OperatorValid = 0; o_PauseGrant = 0.
- o_SampleValid = 0; o_Sample = 0; o_Overrun = 0; o_SampleDropped = 0.
- FSM enters IDLE; period counter = 0.
- Reset mid-sweep aborts the sweep immediately. No partial sample is latched.

Period counter:
- Free-running 0..CLOCKS_PER_SAMPLE-1.
- Tick asserts when the counter == CLOCKS_PER_SAMPLE-1. The counter wraps to 0 on the following cycle.
- The counter runs in every FSM state, including PAUSED.

FSM states: IDLE, SWEEP, DRAIN, PAUSED.
- IDLE:
  - If i_PauseRequest is high, go to PAUSED. Pause has priority over a simultaneous tick, and that tick is skipped with no overrun.
  - Otherwise, on tick, go to SWEEP.
  - o_VoiceOperator is held at 0x00. It must never rest at 0xff, because the generator decodes 0xff as end of sweep.
- SWEEP:
  - Each cycle: o_OperatorValid = 1 and o_VoiceOperator = index.
  - index runs 0..NUM_OPERATOR_SLOTS-1, exactly one per cycle, with no stalls.
  - After the cycle carrying the last ID, go to DRAIN. o_VoiceOperator returns to 0x00 the next cycle.
- DRAIN:
  - Wait for i_SampleReady, then go to IDLE on the next cycle.
  - An i_SampleReady pulse in any other state is still latched into the output register, but causes no state change.
- PAUSED:
  - o_PauseGrant = 1, registered one cycle after entry.
  - Return to IDLE when i_PauseRequest deasserts. o_PauseGrant falls in the same cycle the state leaves PAUSED.
  - Ticks during PAUSED are skipped silently.
- Overrun: a tick while in SWEEP or DRAIN sets o_Overrun. The tick is discarded; sweeps are never queued.

Output register:
- On i_SampleReady: o_Sample <= i_Sample and o_SampleValid <= 1, one cycle after the pulse.
  - If o_SampleValid was already 1 and i_SampleAck is low that cycle, set o_SampleDropped.
- On i_SampleAck with o_SampleValid and no simultaneous ready: o_SampleValid <= 0.
- Simultaneous ack and ready: load the new sample, valid stays 1, no drop.
- i_SampleAck while o_SampleValid = 0 is ignored.

Sticky flags:
- i_ClearFlags clears both sticky flags.
- If a clear and a set event happen in the same cycle, the set wins.

Decomposition:
- Shared package synth.svh:
  - VoiceOperatorID_t.
  - LAST_VOICE_OPERATOR constant (0xff).
  - Sweep FSM state enum.
  - Default CLOCKS_PER_SAMPLE.
- One natural sub-module: sample_output_register, holding the one-entry valid/ack holding register and the drop flag.
- Period counter and FSM stay in the top module.

Test Plan:
- Reset then run 2 periods, CLOCKS_PER_SAMPLE=300:
  - Sweeps start at cycles 300 and 600 after reset release.
  - Each sweep is 256 consecutive valid IDs 0x00..0xff.
  - o_VoiceOperator is 0x00 on every cycle between sweeps.
- Model generator pulses i_SampleReady 5 cycles after ID 0xff with i_Sample = -1234:
  - o_SampleValid rises next cycle with o_Sample = -1234.
  - Ack clears valid.
- CLOCKS_PER_SAMPLE=270 with SampleReady withheld 20 cycles:
  - Tick lands in DRAIN, so o_Overrun = 1 and no second sweep starts that period.
  - i_ClearFlags returns o_Overrun to 0.
- Never ack, with two samples 0x1000 then 0x2000:
  - o_Sample = 0x2000 and o_SampleDropped = 1.
  - Repeat with ack in the same cycle as the second ready: o_SampleDropped stays 0.
- Raise i_PauseRequest mid-sweep at ID 0x40:
  - Sweep completes through 0xff and DRAIN.
  - Grant follows one cycle after entering PAUSED.
  - No sweeps while held.
  - Release resumes at the next tick.
- Assert i_Reset asynchronously at ID 0x80:
  - All outputs go to reset values immediately, with no clock edge needed.
  - After release, the first sweep starts at a full period.

Source files
------------

// File: rtl/operator_sweep_controller_pkg.sv
// Shared types and constants for the per-sample operator sweep sequencer.
package operator_sweep_controller_pkg;

  typedef logic [7:0] VoiceOperatorID_t;

  // The generator decodes this ID as end-of-sweep, so it must never rest on the bus.
  localparam VoiceOperatorID_t LAST_VOICE_OPERATOR = 8'hFF;

  localparam int DEFAULT_CLOCKS_PER_SAMPLE = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_PAUSED = 2'd3
  } SweepState_t;

  function automatic logic f_StickyNext(input logic i_Current, input logic i_Set,
                                        input logic i_Clear);
    return i_Set | (i_Current & ~i_Clear);
  endfunction

endpackage

// File: rtl/operator_sweep_controller_sample_output_register.sv
// One-entry valid/ack holding register for finished samples, with sticky drop flag.
module operator_sweep_controller_sample_output_register
  import operator_sweep_controller_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_SampleReady,
  input  logic [15:0] i_Sample,
  input  logic        i_SampleAck,
  input  logic        i_ClearFlags,
  output logic        o_SampleValid,
  output logic [15:0] o_Sample,
  output logic        o_SampleDropped
);

  logic        r_Valid;
  logic [15:0] r_Sample;
  logic        r_Dropped;
  logic        w_DropSet;

  // An unacked sample is lost only when a new one lands without a same-cycle ack.
  assign w_DropSet = i_SampleReady & r_Valid & ~i_SampleAck;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Valid   <= 1'b0;
      r_Sample  <= 16'h0000;
      r_Dropped <= 1'b0;
    end else begin
      if (i_SampleReady) begin
        r_Valid  <= 1'b1;
        r_Sample <= i_Sample;
      end else if (i_SampleAck) begin
        r_Valid  <= 1'b0;
        r_Sample <= r_Sample;
      end else begin
        r_Valid  <= r_Valid;
        r_Sample <= r_Sample;
      end
      r_Dropped <= f_StickyNext(r_Dropped, w_DropSet, i_ClearFlags);
    end
  end

  assign o_SampleValid   = r_Valid;
  assign o_Sample        = r_Sample;
  assign o_SampleDropped = r_Dropped;

endmodule

// File: rtl/operator_sweep_controller.sv
// Per-sample-period sequencer: sweeps all operator IDs, waits for the sample,
// and offers the host a pause window with no sweep in flight.
module operator_sweep_controller
  import operator_sweep_controller_pkg::*;
#(
  parameter int CLOCKS_PER_SAMPLE  = DEFAULT_CLOCKS_PER_SAMPLE,
  parameter int NUM_OPERATOR_SLOTS = int'(LAST_VOICE_OPERATOR) + 1
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_PauseRequest,
  output logic        o_PauseGrant,
  output logic [7:0]  o_VoiceOperator,
  output logic        o_OperatorValid,
  input  logic        i_SampleReady,
  input  logic [15:0] i_Sample,
  output logic        o_SampleValid,
  output logic [15:0] o_Sample,
  input  logic        i_SampleAck,
  output logic        o_Overrun,
  output logic        o_SampleDropped,
  input  logic        i_ClearFlags
);

  localparam int               CW         = $clog2(CLOCKS_PER_SAMPLE);
  localparam logic [CW-1:0]    LAST_COUNT = CW'(CLOCKS_PER_SAMPLE - 1);
  localparam VoiceOperatorID_t LAST_INDEX = VoiceOperatorID_t'(NUM_OPERATOR_SLOTS - 1);

  logic [CW-1:0]    r_PeriodCount;
  logic             w_Tick;
  SweepState_t      r_State;
  SweepState_t      w_NextState;
  VoiceOperatorID_t r_Index;
  VoiceOperatorID_t w_NextIndex;
  logic             w_OverrunSet;
  logic             r_OperatorValid;
  VoiceOperatorID_t r_VoiceOperator;
  logic             r_PauseGrant;
  logic             r_Overrun;

  assign w_Tick = (r_PeriodCount == LAST_COUNT);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_PeriodCount <= '0;
    end else if (w_Tick) begin
      r_PeriodCount <= '0;
    end else begin
      r_PeriodCount <= r_PeriodCount + CW'(1);
    end
  end

  always_comb begin
    w_NextState  = r_State;
    w_NextIndex  = r_Index;
    w_OverrunSet = 1'b0;
    case (r_State)
      ST_IDLE: begin
        // Pause beats a simultaneous tick; that tick is simply lost.
        if (i_PauseRequest) begin
          w_NextState = ST_PAUSED;
        end else if (w_Tick) begin
          w_NextState = ST_SWEEP;
          w_NextIndex = 8'h00;
        end else begin
          w_NextState = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        w_OverrunSet = w_Tick;
        if (r_Index == LAST_INDEX) begin
          w_NextState = ST_DRAIN;
          w_NextIndex = 8'h00;
        end else begin
          w_NextIndex = r_Index + 8'd1;
        end
      end
      ST_DRAIN: begin
        w_OverrunSet = w_Tick;
        if (i_SampleReady) begin
          w_NextState = ST_IDLE;
        end else begin
          w_NextState = ST_DRAIN;
        end
      end
      ST_PAUSED: begin
        if (i_PauseRequest) begin
          w_NextState = ST_PAUSED;
        end else begin
          w_NextState = ST_IDLE;
        end
      end
      default: begin
        w_NextState = ST_IDLE;
        w_NextIndex = 8'h00;
      end
    endcase
  end

  // Outputs are decoded from the next state so they align with the state they describe.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State         <= ST_IDLE;
      r_Index         <= 8'h00;
      r_OperatorValid <= 1'b0;
      r_VoiceOperator <= 8'h00;
      r_PauseGrant    <= 1'b0;
      r_Overrun       <= 1'b0;
    end else begin
      r_State         <= w_NextState;
      r_Index         <= w_NextIndex;
      r_OperatorValid <= (w_NextState == ST_SWEEP);
      r_VoiceOperator <= (w_NextState == ST_SWEEP) ? w_NextIndex : 8'h00;
      r_PauseGrant    <= (r_State == ST_PAUSED) && (w_NextState == ST_PAUSED);
      r_Overrun       <= f_StickyNext(r_Overrun, w_OverrunSet, i_ClearFlags);
    end
  end

  assign o_OperatorValid = r_OperatorValid;
  assign o_VoiceOperator = r_VoiceOperator;
  assign o_PauseGrant    = r_PauseGrant;
  assign o_Overrun       = r_Overrun;

  operator_sweep_controller_sample_output_register u_output_register (
    .i_Clock         (i_Clock),
    .i_Reset         (i_Reset),
    .i_SampleReady   (i_SampleReady),
    .i_Sample        (i_Sample),
    .i_SampleAck     (i_SampleAck),
    .i_ClearFlags    (i_ClearFlags),
    .o_SampleValid   (o_SampleValid),
    .o_Sample        (o_Sample),
    .o_SampleDropped (o_SampleDropped)
  );

endmodule

// File: tb/tb_operator_sweep_controller.sv
// Scoreboard bench: stimulus queues expected sweep start cycles and consumed samples;
// a negedge monitor pops and compares. A second instance covers the overrun case.
module tb_operator_sweep_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_pause, a_ready, a_ack, a_clear;
  logic [15:0] a_sample;
  logic        a_grant, a_opv, a_sv, a_ovr, a_drop;
  logic [7:0]  a_op;
  logic [15:0] a_so;

  logic        b_pause, b_ready, b_ack, b_clear;
  logic [15:0] b_sample;
  logic        b_grant, b_opv, b_sv, b_ovr, b_drop;
  logic [7:0]  b_op;
  logic [15:0] b_so;

  localparam logic [15:0] SAMPLE_NEG1234 = 16'hFB2E;

  operator_sweep_controller #(.CLOCKS_PER_SAMPLE(300), .NUM_OPERATOR_SLOTS(256)) u_dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_PauseRequest(a_pause), .o_PauseGrant(a_grant),
    .o_VoiceOperator(a_op), .o_OperatorValid(a_opv), .i_SampleReady(a_ready),
    .i_Sample(a_sample), .o_SampleValid(a_sv), .o_Sample(a_so), .i_SampleAck(a_ack),
    .o_Overrun(a_ovr), .o_SampleDropped(a_drop), .i_ClearFlags(a_clear)
  );

  operator_sweep_controller #(.CLOCKS_PER_SAMPLE(270), .NUM_OPERATOR_SLOTS(256)) u_dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_PauseRequest(b_pause), .o_PauseGrant(b_grant),
    .o_VoiceOperator(b_op), .o_OperatorValid(b_opv), .i_SampleReady(b_ready),
    .i_Sample(b_sample), .o_SampleValid(b_sv), .o_Sample(b_so), .i_SampleAck(b_ack),
    .o_Overrun(b_ovr), .o_SampleDropped(b_drop), .i_ClearFlags(b_clear)
  );

  int          cyc;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          idle_err = 0;
  int          exp_sweep_q[$];
  logic [15:0] exp_samp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor for DUT A: sweep shape/timing and samples consumed by the DAC.
  initial begin
    logic mon_prev_v;
    int   mon_idx;
    int   mon_err;
    int   exp_c;
    mon_prev_v = 1'b0;
    mon_idx    = 0;
    mon_err    = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        mon_prev_v = 1'b0;
        mon_idx    = 0;
        mon_err    = 0;
      end else begin
        if (a_opv) begin
          if (!mon_prev_v) begin
            if (exp_sweep_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL sweep_unexpected: sweep started at cycle %0d, none expected", cyc);
            end else begin
              exp_c = exp_sweep_q.pop_front();
              check("sweep_start_cycle", cyc, exp_c);
            end
            mon_idx = 0;
            mon_err = 0;
          end
          if (a_op !== mon_idx[7:0]) mon_err++;
          mon_idx++;
        end else begin
          if (mon_prev_v) begin
            check("sweep_length", mon_idx, 256);
            check("sweep_id_sequence_errors", mon_err, 0);
          end
          if (a_op !== 8'h00) idle_err++;
        end
        mon_prev_v = a_opv;
        if (a_ack && a_sv) begin
          if (exp_samp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sample_unexpected: consumed 0x%0h, none expected", a_so);
          end else begin
            check("sample_consumed", {16'h0000, a_so}, {16'h0000, exp_samp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ready_a(input int c, input logic [15:0] val);
    to_cycle(c);
    a_ready  = 1'b1;
    a_sample = val;
    to_cycle(c + 1);
    a_ready  = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_op"},    {24'h0, a_op}, 32'h0);
    check({tag, "_opv"},   {31'h0, a_opv}, 32'h0);
    check({tag, "_grant"}, {31'h0, a_grant}, 32'h0);
    check({tag, "_sv"},    {31'h0, a_sv}, 32'h0);
    check({tag, "_so"},    {16'h0, a_so}, 32'h0);
    check({tag, "_ovr"},   {31'h0, a_ovr}, 32'h0);
    check({tag, "_drop"},  {31'h0, a_drop}, 32'h0);
  endtask

  // Overrun scenario on the 270-cycle instance: sample withheld 20 cycles past 0xff.
  task automatic run_b();
    int hits;
    to_cycle(269);
    check("b_no_sweep_before_tick", {31'h0, b_opv}, 32'h0);
    to_cycle(270);
    check("b_sweep_start_valid", {31'h0, b_opv}, 32'h1);
    check("b_sweep_first_id", {24'h0, b_op}, 32'h0);
    to_cycle(525);
    check("b_sweep_last_id", {24'h0, b_op}, 32'hFF);
    to_cycle(539);
    check("b_overrun_before_tick", {31'h0, b_ovr}, 32'h0);
    to_cycle(540);
    check("b_overrun_set", {31'h0, b_ovr}, 32'h1);
    b_clear = 1'b1;
    to_cycle(541);
    b_clear = 1'b0;
    to_cycle(542);
    check("b_overrun_cleared", {31'h0, b_ovr}, 32'h0);
    to_cycle(545);
    b_ready  = 1'b1;
    b_sample = 16'h0123;
    to_cycle(546);
    b_ready  = 1'b0;
    check("b_sample_latched", {15'h0, b_sv, b_so}, {15'h0, 1'b1, 16'h0123});
    hits = 0;
    while (cyc < 810) begin
      if (b_opv) hits++;
      @(posedge clk);
      #1;
    end
    check("b_no_sweep_rest_of_period", hits, 0);
    check("b_next_sweep_valid", {31'h0, b_opv}, 32'h1);
    check("b_next_sweep_first_id", {24'h0, b_op}, 32'h0);
    check("b_no_grant_no_drop", {30'h0, b_grant, b_drop}, 32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    a_pause  = 1'b0; a_ready = 1'b0; a_ack = 1'b0; a_clear = 1'b0; a_sample = 16'h0000;
    b_pause  = 1'b0; b_ready = 1'b0; b_ack = 1'b0; b_clear = 1'b0; b_sample = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_a("reset");
    fork
      run_b();
    join_none

    exp_sweep_q.push_back(300);
    exp_sweep_q.push_back(600);
    exp_sweep_q.push_back(900);
    exp_sweep_q.push_back(1200);
    exp_sweep_q.push_back(2100);

    // Sweep 1: generator answers 5 cycles after 0xff with -1234.
    pulse_ready_a(560, SAMPLE_NEG1234);
    check("neg_sample_valid", {31'h0, a_sv}, 32'h1);
    check("neg_sample_value", {16'h0, a_so}, {16'h0, SAMPLE_NEG1234});
    to_cycle(563);
    exp_samp_q.push_back(SAMPLE_NEG1234);
    a_ack = 1'b1;
    to_cycle(564);
    a_ack = 1'b0;
    check("ack_clears_valid", {31'h0, a_sv}, 32'h0);

    // Sweep 2: two samples, no ack in between -> drop.
    pulse_ready_a(860, 16'h1000);
    pulse_ready_a(870, 16'h2000);
    check("drop_keeps_newest", {16'h0, a_so}, 32'h2000);
    check("drop_flag_set", {31'h0, a_drop}, 32'h1);
    check("no_overrun_normal", {31'h0, a_ovr}, 32'h0);
    to_cycle(875);
    a_clear = 1'b1;
    to_cycle(876);
    a_clear = 1'b0;
    check("drop_flag_cleared", {31'h0, a_drop}, 32'h0);
    to_cycle(880);
    exp_samp_q.push_back(16'h2000);
    a_ack = 1'b1;
    to_cycle(881);
    a_ack = 1'b0;

    // Sweep 3: second ready coincides with ack -> no drop.
    pulse_ready_a(1160, 16'h3000);
    to_cycle(1170);
    exp_samp_q.push_back(16'h3000);
    exp_samp_q.push_back(16'h4000);
    a_ready  = 1'b1;
    a_sample = 16'h4000;
    a_ack    = 1'b1;
    to_cycle(1171);
    a_ready  = 1'b0;
    a_ack    = 1'b0;
    check("ack_ready_no_drop", {31'h0, a_drop}, 32'h0);
    check("ack_ready_valid", {31'h0, a_sv}, 32'h1);
    check("ack_ready_value", {16'h0, a_so}, 32'h4000);
    to_cycle(1180);
    a_ack = 1'b1;
    to_cycle(1181);
    a_ack = 1'b0;
    check("ack_only_clears", {31'h0, a_sv}, 32'h0);

    // Sweep 4: pause requested mid-sweep at ID 0x40.
    to_cycle(1264);
    check("pause_at_id40", {24'h0, a_op}, 32'h40);
    a_pause = 1'b1;
    pulse_ready_a(1460, 16'h0555);
    to_cycle(1462);
    check("grant_low_on_entry", {31'h0, a_grant}, 32'h0);
    to_cycle(1463);
    check("grant_high_after_entry", {31'h0, a_grant}, 32'h1);
    to_cycle(1465);
    exp_samp_q.push_back(16'h0555);
    a_ack = 1'b1;
    to_cycle(1466);
    a_ack = 1'b0;
    to_cycle(1500);
    check("no_sweep_while_paused", {31'h0, a_opv}, 32'h0);
    to_cycle(1850);
    check("grant_held", {31'h0, a_grant}, 32'h1);
    a_pause = 1'b0;
    to_cycle(1851);
    check("grant_falls_on_release", {31'h0, a_grant}, 32'h0);
    to_cycle(2099);
    check("no_overrun_while_paused", {31'h0, a_ovr}, 32'h0);
    check("idle_before_resume", {31'h0, a_opv}, 32'h0);

    // Sweep 5: leave state behind, then asynchronous reset at ID 0x80.
    pulse_ready_a(2110, 16'h7777);
    pulse_ready_a(2120, 16'h7778);
    check("pre_reset_drop", {31'h0, a_drop}, 32'h1);
    to_cycle(2228);
    check("reset_at_id80", {24'h0, a_op}, 32'h80);
    #2 rst = 1'b1;
    #1 check_reset_a("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    exp_sweep_q.push_back(300);
    pulse_ready_a(560, 16'h0ABC);
    to_cycle(562);
    exp_samp_q.push_back(16'h0ABC);
    a_ack = 1'b1;
    to_cycle(563);
    a_ack = 1'b0;
    to_cycle(570);

    check("sweeps_all_seen", exp_sweep_q.size(), 0);
    check("samples_all_consumed", exp_samp_q.size(), 0);
    check("idle_id_always_zero", idle_err, 0);
    check("final_flags", {30'h0, a_ovr, a_drop}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
